// File: rtl/phase_sync_pkg.sv
// Shared definitions for the lockstep phase scheduler: marker codes, FSM states
// and the commit-stream marker decode (slti x0,x0,imm).
package phase_sync_pkg;

  localparam logic [3:0] VCTM_S  = 4'd0;
  localparam logic [3:0] VCTM_E  = 4'd1;
  localparam logic [3:0] TEXE_S  = 4'd2;
  localparam logic [3:0] TEXE_E  = 4'd3;
  localparam logic [3:0] CHK_S   = 4'd4;
  localparam logic [3:0] CHK_E   = 4'd5;
  localparam logic [3:0] LEAK_S  = 4'd6;
  localparam logic [3:0] LEAK_E  = 4'd7;
  localparam logic [3:0] INIT_S  = 4'd8;
  localparam logic [3:0] INIT_E  = 4'd9;
  localparam logic [3:0] BOOT_S  = 4'd10;
  localparam logic [3:0] BOOT_E  = 4'd11;
  localparam logic [3:0] TRAIN_S = 4'd12;
  localparam logic [3:0] TRAIN_E = 4'd13;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_DUT = 2'd1,
    WAIT_VNT = 2'd2,
    ERR      = 2'd3
  } state_e;

  // Only slti x0,x0,imm with imm[3:0] in the defined code range is a marker.
  function automatic logic is_marker(input logic [31:0] inst);
    return (inst[31:24] == 8'h00) && (inst[19:0] == 20'h02013) && (inst[23:20] <= TRAIN_E);
  endfunction

endpackage

// File: rtl/phase_sync_ctrl_marker_dec.sv
// Per-core marker decoder: picks the lowest-index marker lane in a commit
// bundle and flags any additional marker lanes.
module phase_marker_dec
  import phase_sync_pkg::*;
#(
  parameter int COMMIT_W = 2
) (
  input  logic [COMMIT_W-1:0]    cmt_valid,
  input  logic [32*COMMIT_W-1:0] cmt_inst,
  output logic                   hit,
  output logic [3:0]             code,
  output logic                   multi
);

  logic lane_hit;

  // Priority scan from lane 0 upward.
  always_comb begin
    hit      = 1'b0;
    code     = 4'd0;
    multi    = 1'b0;
    lane_hit = 1'b0;
    for (int i = 0; i < COMMIT_W; i++) begin
      lane_hit = cmt_valid[i] && is_marker(cmt_inst[32*i +: 32]);
      if (lane_hit && hit) begin
        multi = 1'b1;
      end else if (lane_hit) begin
        hit  = 1'b1;
        code = cmt_inst[32*i+20 +: 4];
      end else begin
        multi = multi;
      end
    end
  end

endmodule

// File: rtl/phase_sync_ctrl.sv
// Lockstep phase scheduler between the DUT and variant commit streams: stalls the
// leading core at each marker, flags divergence/timeouts and logs marker events.
module phase_sync_ctrl
  import phase_sync_pkg::*;
#(
  parameter int COMMIT_W = 2,
  parameter int TIMEOUT  = 4096,
  parameter int CNT_W    = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   sync_en,
  input  logic [COMMIT_W-1:0]    dut_cmt_valid,
  input  logic [32*COMMIT_W-1:0] dut_cmt_inst,
  input  logic [COMMIT_W-1:0]    vnt_cmt_valid,
  input  logic [32*COMMIT_W-1:0] vnt_cmt_inst,
  output logic                   dut_stall,
  output logic                   vnt_stall,
  output logic                   evt_valid,
  output logic [3:0]             evt_code,
  output logic                   evt_is_dut,
  output logic [CNT_W-1:0]       evt_id,
  output logic [3:0]             phase_cur,
  output logic [CNT_W-1:0]       phase_cycles,
  output logic                   err_diverge,
  output logic                   err_timeout,
  output logic                   err_multi
);

  localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic       dut_hit, vnt_hit, dut_multi, vnt_multi;
  logic [3:0] dut_code, vnt_code;

  phase_marker_dec #(.COMMIT_W(COMMIT_W)) u_dut_dec (
    .cmt_valid (dut_cmt_valid),
    .cmt_inst  (dut_cmt_inst),
    .hit       (dut_hit),
    .code      (dut_code),
    .multi     (dut_multi)
  );

  phase_marker_dec #(.COMMIT_W(COMMIT_W)) u_vnt_dec (
    .cmt_valid (vnt_cmt_valid),
    .cmt_inst  (vnt_cmt_inst),
    .hit       (vnt_hit),
    .code      (vnt_code),
    .multi     (vnt_multi)
  );

  state_e             state_q, state_d;
  logic [3:0]         wait_code_q, wait_code_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               dut_stall_q, dut_stall_d, vnt_stall_q, vnt_stall_d;
  logic               evt_valid_q, evt_valid_d, evt_is_dut_q, evt_is_dut_d;
  logic [3:0]         evt_code_q, evt_code_d;
  logic [CNT_W-1:0]   evt_id_q, evt_id_d;
  logic               skid_valid_q, skid_valid_d, skid_is_dut_q, skid_is_dut_d;
  logic [3:0]         skid_code_q, skid_code_d;
  logic [CNT_W-1:0]   skid_id_q, skid_id_d;
  logic [CNT_W-1:0]   dut_cnt_q, dut_cnt_d, vnt_cnt_q, vnt_cnt_d;
  logic [3:0]         phase_cur_q, phase_cur_d;
  logic [CNT_W-1:0]   phase_cycles_q, phase_cycles_d;
  logic               err_diverge_q, err_diverge_d, err_timeout_q, err_timeout_d;
  logic               err_multi_q, err_multi_d;
  logic               agree;

  // Event path: the skid entry is oldest, then DUT, then variant; one event leaves
  // per cycle, at most one waits in the skid and anything beyond that is dropped.
  always_comb begin
    evt_valid_d   = 1'b0;
    evt_code_d    = 4'd0;
    evt_is_dut_d  = 1'b0;
    evt_id_d      = '0;
    skid_valid_d  = 1'b0;
    skid_code_d   = skid_code_q;
    skid_is_dut_d = skid_is_dut_q;
    skid_id_d     = skid_id_q;
    if (skid_valid_q) begin
      evt_valid_d  = 1'b1;
      evt_code_d   = skid_code_q;
      evt_is_dut_d = skid_is_dut_q;
      evt_id_d     = skid_id_q;
      if (dut_hit) begin
        skid_valid_d  = 1'b1;
        skid_code_d   = dut_code;
        skid_is_dut_d = 1'b1;
        skid_id_d     = dut_cnt_q;
      end else if (vnt_hit) begin
        skid_valid_d  = 1'b1;
        skid_code_d   = vnt_code;
        skid_is_dut_d = 1'b0;
        skid_id_d     = vnt_cnt_q;
      end else begin
        skid_valid_d = 1'b0;
      end
    end else if (dut_hit) begin
      evt_valid_d  = 1'b1;
      evt_code_d   = dut_code;
      evt_is_dut_d = 1'b1;
      evt_id_d     = dut_cnt_q;
      if (vnt_hit) begin
        skid_valid_d  = 1'b1;
        skid_code_d   = vnt_code;
        skid_is_dut_d = 1'b0;
        skid_id_d     = vnt_cnt_q;
      end else begin
        skid_valid_d = 1'b0;
      end
    end else if (vnt_hit) begin
      evt_valid_d  = 1'b1;
      evt_code_d   = vnt_code;
      evt_is_dut_d = 1'b0;
      evt_id_d     = vnt_cnt_q;
    end else begin
      evt_valid_d = 1'b0;
    end
    dut_cnt_d   = dut_hit ? dut_cnt_q + CNT_W'(1'b1) : dut_cnt_q;
    vnt_cnt_d   = vnt_hit ? vnt_cnt_q + CNT_W'(1'b1) : vnt_cnt_q;
    err_multi_d = err_multi_q | dut_multi | vnt_multi;
  end

  // Lockstep FSM; stalls are derived from the next state so they are registered.
  always_comb begin
    state_d       = state_q;
    wait_code_d   = wait_code_q;
    wait_cnt_d    = wait_cnt_q;
    phase_cur_d   = phase_cur_q;
    err_diverge_d = err_diverge_q;
    err_timeout_d = err_timeout_q;
    agree         = 1'b0;
    if (!sync_en) begin
      state_d = (state_q == ERR) ? ERR : RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (dut_hit && vnt_hit) begin
            if (dut_code == vnt_code) begin
              agree       = 1'b1;
              phase_cur_d = dut_code;
            end else begin
              state_d       = ERR;
              err_diverge_d = 1'b1;
            end
          end else if (dut_hit) begin
            state_d     = WAIT_VNT;
            wait_code_d = dut_code;
            wait_cnt_d  = '0;
          end else if (vnt_hit) begin
            state_d     = WAIT_DUT;
            wait_code_d = vnt_code;
            wait_cnt_d  = '0;
          end else begin
            state_d = RUN;
          end
        end
        WAIT_VNT: begin
          // A further DUT marker means the stall was not honoured.
          if (dut_hit || (vnt_hit && (vnt_code != wait_code_q))) begin
            state_d       = ERR;
            err_diverge_d = 1'b1;
          end else if (vnt_hit) begin
            state_d     = RUN;
            agree       = 1'b1;
            phase_cur_d = wait_code_q;
          end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
            state_d       = ERR;
            err_timeout_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1'b1);
          end
        end
        WAIT_DUT: begin
          if (vnt_hit || (dut_hit && (dut_code != wait_code_q))) begin
            state_d       = ERR;
            err_diverge_d = 1'b1;
          end else if (dut_hit) begin
            state_d     = RUN;
            agree       = 1'b1;
            phase_cur_d = wait_code_q;
          end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
            state_d       = ERR;
            err_timeout_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1'b1);
          end
        end
        ERR:     state_d = ERR;
        default: state_d = ERR;
      endcase
    end
    dut_stall_d = (state_d == WAIT_VNT);
    vnt_stall_d = (state_d == WAIT_DUT);
    if (agree) begin
      phase_cycles_d = '0;
    end else if (phase_cycles_q == {CNT_W{1'b1}}) begin
      phase_cycles_d = phase_cycles_q;
    end else begin
      phase_cycles_d = phase_cycles_q + CNT_W'(1'b1);
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= RUN;
      wait_code_q    <= 4'd0;
      wait_cnt_q     <= '0;
      dut_stall_q    <= 1'b0;
      vnt_stall_q    <= 1'b0;
      evt_valid_q    <= 1'b0;
      evt_code_q     <= 4'd0;
      evt_is_dut_q   <= 1'b0;
      evt_id_q       <= '0;
      skid_valid_q   <= 1'b0;
      skid_code_q    <= 4'd0;
      skid_is_dut_q  <= 1'b0;
      skid_id_q      <= '0;
      dut_cnt_q      <= '0;
      vnt_cnt_q      <= '0;
      phase_cur_q    <= 4'd0;
      phase_cycles_q <= '0;
      err_diverge_q  <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_multi_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_code_q    <= wait_code_d;
      wait_cnt_q     <= wait_cnt_d;
      dut_stall_q    <= dut_stall_d;
      vnt_stall_q    <= vnt_stall_d;
      evt_valid_q    <= evt_valid_d;
      evt_code_q     <= evt_code_d;
      evt_is_dut_q   <= evt_is_dut_d;
      evt_id_q       <= evt_id_d;
      skid_valid_q   <= skid_valid_d;
      skid_code_q    <= skid_code_d;
      skid_is_dut_q  <= skid_is_dut_d;
      skid_id_q      <= skid_id_d;
      dut_cnt_q      <= dut_cnt_d;
      vnt_cnt_q      <= vnt_cnt_d;
      phase_cur_q    <= phase_cur_d;
      phase_cycles_q <= phase_cycles_d;
      err_diverge_q  <= err_diverge_d;
      err_timeout_q  <= err_timeout_d;
      err_multi_q    <= err_multi_d;
    end
  end

  assign dut_stall    = dut_stall_q;
  assign vnt_stall    = vnt_stall_q;
  assign evt_valid    = evt_valid_q;
  assign evt_code     = evt_code_q;
  assign evt_is_dut   = evt_is_dut_q;
  assign evt_id       = evt_id_q;
  assign phase_cur    = phase_cur_q;
  assign phase_cycles = phase_cycles_q;
  assign err_diverge  = err_diverge_q;
  assign err_timeout  = err_timeout_q;
  assign err_multi    = err_multi_q;

endmodule

// File: tb/tb_phase_sync_ctrl.sv
// Self-checking bench for phase_sync_ctrl: table-driven lockstep vectors, an
// event scoreboard, and hand sequences for divergence, timeout, reset and sync_en.
module tb_phase_sync_ctrl;

  localparam int CW = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          sync_en = 1'b1;
  logic [1:0]    dut_cmt_valid = 2'b00, vnt_cmt_valid = 2'b00;
  logic [63:0]   dut_cmt_inst = 64'd0, vnt_cmt_inst = 64'd0;
  logic          dut_stall, vnt_stall, evt_valid, evt_is_dut;
  logic [3:0]    evt_code, phase_cur;
  logic [CW-1:0] evt_id, phase_cycles;
  logic          err_diverge, err_timeout, err_multi;

  phase_sync_ctrl #(.COMMIT_W(2), .TIMEOUT(16), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .sync_en(sync_en),
    .dut_cmt_valid(dut_cmt_valid), .dut_cmt_inst(dut_cmt_inst),
    .vnt_cmt_valid(vnt_cmt_valid), .vnt_cmt_inst(vnt_cmt_inst),
    .dut_stall(dut_stall), .vnt_stall(vnt_stall),
    .evt_valid(evt_valid), .evt_code(evt_code), .evt_is_dut(evt_is_dut), .evt_id(evt_id),
    .phase_cur(phase_cur), .phase_cycles(phase_cycles),
    .err_diverge(err_diverge), .err_timeout(err_timeout), .err_multi(err_multi)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  logic [CW-1:0] dut_cnt_m = '0, vnt_cnt_m = '0;
  logic [12:0] exp_q[$];

  typedef struct {
    logic [1:0] dv; logic [31:0] d0; logic [31:0] d1;
    logic [1:0] vv; logic [31:0] v0; logic [31:0] v1;
    logic ds; logic vs; logic [3:0] ph; logic mu;
  } vec_t;
  vec_t tbl[13];

  function automatic logic [31:0] mk(input int code);
    logic [31:0] r;
    r = 32'h0000_2013;
    r[23:20] = code[3:0];
    return r;
  endfunction

  function automatic vec_t row(input logic [1:0] dv, input logic [31:0] d0, input logic [31:0] d1,
                               input logic [1:0] vv, input logic [31:0] v0, input logic [31:0] v1,
                               input logic ds, input logic vs, input int ph, input logic mu);
    vec_t r;
    r.dv = dv; r.d0 = d0; r.d1 = d1; r.vv = vv; r.v0 = v0; r.v1 = v1;
    r.ds = ds; r.vs = vs; r.ph = ph[3:0]; r.mu = mu;
    return r;
  endfunction

  // {hit, code} of the lowest-index marker lane.
  function automatic logic [4:0] pick(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1);
    if (v[0] && ((i0 & 32'hFF0F_FFFF) == 32'h0000_2013) && (i0[23:20] < 4'd14)) return {1'b1, i0[23:20]};
    if (v[1] && ((i1 & 32'hFF0F_FFFF) == 32'h0000_2013) && (i1[23:20] < 4'd14)) return {1'b1, i1[23:20]};
    return 5'd0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one commit cycle, queue the expected events, and wait past the edge.
  task automatic drive(input logic [1:0] dv, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [1:0] vv, input logic [31:0] v0, input logic [31:0] v1);
    logic [4:0] pd, pv;
    dut_cmt_valid = dv; dut_cmt_inst = {d1, d0};
    vnt_cmt_valid = vv; vnt_cmt_inst = {v1, v0};
    pd = pick(dv, d0, d1);
    pv = pick(vv, v0, v1);
    if (reset && pd[4]) begin exp_q.push_back({pd[3:0], 1'b1, dut_cnt_m}); dut_cnt_m++; end
    if (reset && pv[4]) begin exp_q.push_back({pv[3:0], 1'b0, vnt_cnt_m}); vnt_cnt_m++; end
    @(posedge clock); #1;
    dut_cmt_valid = 2'b00; vnt_cmt_valid = 2'b00;
  endtask

  task automatic idle();
    drive(2'b00, NOP, NOP, 2'b00, NOP, NOP);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    dut_cnt_m = '0; vnt_cnt_m = '0;
    @(posedge clock); #1;
    @(posedge clock); #1;
  endtask

  // Scoreboard: every event must match the oldest expected one.
  always @(negedge clock) begin
    if (!reset) begin
      exp_q.delete();
    end else if (evt_valid) begin
      if (exp_q.size() == 0) begin
        chk("evt_unexpected", {19'd0, evt_code, evt_is_dut, evt_id}, 32'd0);
      end else begin
        chk("evt", {19'd0, evt_code, evt_is_dut, evt_id}, {19'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    int n;
    tbl[0]  = row(2'b01, mk(8),  NOP,         2'b00, NOP,         NOP,    1'b1, 1'b0, 0,  1'b0);
    tbl[1]  = row(2'b00, NOP,    NOP,         2'b00, NOP,         NOP,    1'b1, 1'b0, 0,  1'b0);
    tbl[2]  = row(2'b00, NOP,    NOP,         2'b00, NOP,         NOP,    1'b1, 1'b0, 0,  1'b0);
    tbl[3]  = row(2'b00, NOP,    NOP,         2'b00, NOP,         NOP,    1'b1, 1'b0, 0,  1'b0);
    tbl[4]  = row(2'b00, NOP,    NOP,         2'b00, NOP,         NOP,    1'b1, 1'b0, 0,  1'b0);
    tbl[5]  = row(2'b00, NOP,    NOP,         2'b01, mk(8),       NOP,    1'b0, 1'b0, 8,  1'b0);
    tbl[6]  = row(2'b01, mk(1),  NOP,         2'b01, mk(1),       NOP,    1'b0, 1'b0, 1,  1'b0);
    tbl[7]  = row(2'b00, NOP,    NOP,         2'b00, NOP,         NOP,    1'b0, 1'b0, 1,  1'b0);
    tbl[8]  = row(2'b11, mk(12), mk(13),      2'b00, NOP,         NOP,    1'b1, 1'b0, 1,  1'b1);
    tbl[9]  = row(2'b00, NOP,    NOP,         2'b11, 32'h00e02013, mk(12), 1'b0, 1'b0, 12, 1'b1);
    tbl[10] = row(2'b10, NOP,    32'h00e02013, 2'b00, NOP,        NOP,    1'b0, 1'b0, 12, 1'b1);
    tbl[11] = row(2'b00, NOP,    NOP,         2'b01, mk(13),      NOP,    1'b0, 1'b1, 12, 1'b1);
    tbl[12] = row(2'b11, NOP,    mk(13),      2'b00, NOP,         NOP,    1'b0, 1'b0, 13, 1'b1);

    do_reset();
    chk("rst_dut_stall", {31'd0, dut_stall}, 32'd0);
    chk("rst_evt_valid", {31'd0, evt_valid}, 32'd0);
    chk("rst_phase", {28'd0, phase_cur}, 32'd0);
    chk("rst_errs", {29'd0, err_diverge, err_timeout, err_multi}, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].dv, tbl[i].d0, tbl[i].d1, tbl[i].vv, tbl[i].v0, tbl[i].v1);
      chk($sformatf("row%0d_dut_stall", i), {31'd0, dut_stall}, {31'd0, tbl[i].ds});
      chk($sformatf("row%0d_vnt_stall", i), {31'd0, vnt_stall}, {31'd0, tbl[i].vs});
      chk($sformatf("row%0d_phase", i), {28'd0, phase_cur}, {28'd0, tbl[i].ph});
      chk($sformatf("row%0d_multi", i), {31'd0, err_multi}, {31'd0, tbl[i].mu});
      chk($sformatf("row%0d_diverge", i), {31'd0, err_diverge}, 32'd0);
    end

    // Divergence: TEXE_START vs LEAK_START, then keep logging with phase frozen.
    drive(2'b01, mk(2), NOP, 2'b01, mk(6), NOP);
    chk("div_flag", {31'd0, err_diverge}, 32'd1);
    chk("div_stalls", {30'd0, dut_stall, vnt_stall}, 32'd0);
    chk("div_phase", {28'd0, phase_cur}, 32'd13);
    idle();
    drive(2'b01, mk(4), NOP, 2'b00, NOP, NOP);
    chk("err_no_stall", {30'd0, dut_stall, vnt_stall}, 32'd0);
    idle();
    drive(2'b00, NOP, NOP, 2'b01, mk(4), NOP);
    chk("err_phase_frozen", {28'd0, phase_cur}, 32'd13);
    for (int i = 0; i < 260; i++) idle();
    chk("phase_cycles_sat", {24'd0, phase_cycles}, 32'd255);

    // Timeout with the variant silent.
    do_reset();
    chk("rst2_state", {22'd0, phase_cur, dut_stall, vnt_stall, err_diverge, err_timeout, err_multi, evt_valid}, 32'd0);
    chk("rst2_cycles", {24'd0, phase_cycles}, 32'd0);
    reset = 1'b1;
    idle(); idle(); idle();
    chk("phase_cycles_cnt", {24'd0, phase_cycles}, 32'd3);
    drive(2'b01, mk(8), NOP, 2'b00, NOP, NOP);
    chk("to_stall_on", {31'd0, dut_stall}, 32'd1);
    n = 0;
    while (n < 40) begin
      idle();
      if (dut_stall) begin
        chk("to_not_early", {31'd0, err_timeout}, 32'd0);
        n++;
      end else begin
        break;
      end
    end
    chk("to_wait_len", n, 32'd15);
    chk("to_flag", {31'd0, err_timeout}, 32'd1);
    chk("to_no_diverge", {31'd0, err_diverge}, 32'd0);

    // Reset mid-wait releases the stall.
    do_reset();
    reset = 1'b1;
    drive(2'b01, mk(0), NOP, 2'b00, NOP, NOP);
    chk("w_stall", {31'd0, dut_stall}, 32'd1);
    reset = 1'b0;
    dut_cnt_m = '0; vnt_cnt_m = '0;
    @(posedge clock); #1;
    chk("rst_mid_wait", {26'd0, phase_cur, dut_stall, err_timeout}, 32'd0);
    reset = 1'b1;

    // Track-only mode never stalls but still logs.
    sync_en = 1'b0;
    drive(2'b01, mk(3), NOP, 2'b00, NOP, NOP);
    for (int i = 0; i < 3; i++) begin
      chk("nosync_stall", {30'd0, dut_stall, vnt_stall}, 32'd0);
      idle();
    end
    sync_en = 1'b1;
    drive(2'b00, NOP, NOP, 2'b01, mk(5), NOP);
    chk("wd_stall", {31'd0, vnt_stall}, 32'd1);
    sync_en = 1'b0;
    idle();
    chk("sync_fall_release", {31'd0, vnt_stall}, 32'd0);
    idle(); idle(); idle();
    chk("evt_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
